// File: rtl/serial_adder_cmp.sv
// Chunk-serial XLEN-bit adder/subtractor producing carry, zero, negative, overflow and a selected compare.
// Defining SERIAL_ADDER_FLUSH_EN adds a flush_i port that abandons an in-flight operation.
module serial_adder_cmp #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
`ifdef SERIAL_ADDER_FLUSH_EN
  input  logic            flush_i,
`endif
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            sub_i,
  input  logic [5:0]      sel_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] sum_o,
  output logic            cout_o,
  output logic            zero_o,
  output logic            neg_o,
  output logic            ovf_o,
  output logic            cmp_o
);

  localparam int unsigned NCHUNK = XLEN / CHUNK;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned MSB    = XLEN - 1;

  localparam logic [5:0] SEL_EQ  = 6'b000001;
  localparam logic [5:0] SEL_NE  = 6'b000010;
  localparam logic [5:0] SEL_LTU = 6'b000100;
  localparam logic [5:0] SEL_GEU = 6'b001000;
  localparam logic [5:0] SEL_LT  = 6'b010000;
  localparam logic [5:0] SEL_GE  = 6'b100000;

  if ((XLEN % CHUNK) != 0) begin : g_chunk_check
    $error("serial_adder_cmp: XLEN must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              nz_q, nz_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              sub_q, sub_d;
  logic [5:0]        sel_q, sel_d;
  logic [XLEN-1:0]   sum_q, sum_d;
  logic [XLEN-1:0]   res_sum_q, res_sum_d;
  logic              res_cout_q, res_cout_d;
  logic              res_zero_q, res_zero_d;
  logic              res_neg_q, res_neg_d;
  logic              res_ovf_q, res_ovf_d;
  logic              res_cmp_q, res_cmp_d;

  logic              flush;
  logic [CHUNK-1:0]  a_chunk [NCHUNK];
  logic [CHUNK-1:0]  b_chunk [NCHUNK];
  logic [CHUNK-1:0]  a_ch;
  logic [CHUNK-1:0]  b_ch;
  logic [CHUNK:0]    add_w;
  logic [XLEN-1:0]   sum_next;
  logic              nz_next;
  logic              ovf_next;
  logic              cmp_next;

`ifdef SERIAL_ADDER_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Chunk datapath: the counter selects which slice of A/B feeds the adder and which sum slice is replaced.
  for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
    assign a_chunk[g] = a_q[g*CHUNK +: CHUNK];
    assign b_chunk[g] = b_q[g*CHUNK +: CHUNK];
    assign sum_next[g*CHUNK +: CHUNK] = (cnt_q == CNT_W'(g)) ? add_w[CHUNK-1:0]
                                                              : sum_q[g*CHUNK +: CHUNK];
  end

  assign a_ch     = a_chunk[cnt_q];
  assign b_ch     = b_chunk[cnt_q];
  assign add_w    = {1'b0, a_ch} + {1'b0, (sub_q ? ~b_ch : b_ch)} + (CHUNK+1)'(carry_q);
  assign nz_next  = nz_q | (|add_w[CHUNK-1:0]);
  assign ovf_next = (sub_q ? (a_q[MSB] ^ b_q[MSB]) : ~(a_q[MSB] ^ b_q[MSB]))
                    & (a_q[MSB] ^ sum_next[MSB]);

  // Compare result, only meaningful on the last chunk when sum_next/add_w hold final values.
  always_comb begin
    cmp_next = 1'b0;
    case (sel_q)
      SEL_EQ:  cmp_next = ~nz_next;
      SEL_NE:  cmp_next = nz_next;
      SEL_LTU: cmp_next = sub_q ? ~add_w[CHUNK] : 1'b0;
      SEL_GEU: cmp_next = sub_q ? add_w[CHUNK] : 1'b1;
      SEL_LT:  cmp_next = sub_q ? (sum_next[MSB] ^ ovf_next) : 1'b0;
      SEL_GE:  cmp_next = sub_q ? ~(sum_next[MSB] ^ ovf_next) : 1'b1;
      default: cmp_next = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    nz_d       = nz_q;
    a_d        = a_q;
    b_d        = b_q;
    sub_d      = sub_q;
    sel_d      = sel_q;
    sum_d      = sum_q;
    res_sum_d  = res_sum_q;
    res_cout_d = res_cout_q;
    res_zero_d = res_zero_q;
    res_neg_d  = res_neg_q;
    res_ovf_d  = res_ovf_q;
    res_cmp_d  = res_cmp_q;

    case (state_q)
      IDLE: begin
        if (!flush && in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          sub_d   = sub_i;
          sel_d   = sel_i;
          carry_d = sub_i;
          nz_d    = 1'b0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          sum_d   = sum_next;
          carry_d = add_w[CHUNK];
          nz_d    = nz_next;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NCHUNK - 1)) begin
            res_sum_d  = sum_next;
            res_cout_d = add_w[CHUNK];
            res_zero_d = ~nz_next;
            res_neg_d  = sum_next[MSB];
            res_ovf_d  = ovf_next;
            res_cmp_d  = cmp_next;
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        if (flush || out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      nz_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      sel_q      <= '0;
      sum_q      <= '0;
      res_sum_q  <= '0;
      res_cout_q <= 1'b0;
      res_zero_q <= 1'b0;
      res_neg_q  <= 1'b0;
      res_ovf_q  <= 1'b0;
      res_cmp_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      nz_q       <= nz_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sub_q      <= sub_d;
      sel_q      <= sel_d;
      sum_q      <= sum_d;
      res_sum_q  <= res_sum_d;
      res_cout_q <= res_cout_d;
      res_zero_q <= res_zero_d;
      res_neg_q  <= res_neg_d;
      res_ovf_q  <= res_ovf_d;
      res_cmp_q  <= res_cmp_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign sum_o       = res_sum_q;
  assign cout_o      = res_cout_q;
  assign zero_o      = res_zero_q;
  assign neg_o       = res_neg_q;
  assign ovf_o       = res_ovf_q;
  assign cmp_o       = res_cmp_q;

endmodule

// File: tb/tb_serial_adder_cmp.sv
// Directed bench for serial_adder_cmp: expected results are queued at accept and checked when out_valid_o rises.
module tb_serial_adder_cmp;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CHUNK  = 8;
  localparam int unsigned NCHUNK = XLEN / CHUNK;

  localparam logic [5:0] SEL_EQ  = 6'b000001;
  localparam logic [5:0] SEL_NE  = 6'b000010;
  localparam logic [5:0] SEL_LTU = 6'b000100;
  localparam logic [5:0] SEL_GEU = 6'b001000;
  localparam logic [5:0] SEL_LT  = 6'b010000;
  localparam logic [5:0] SEL_GE  = 6'b100000;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        zero;
    logic        neg;
    logic        ovf;
    logic        cmp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic [5:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        zero;
  logic        neg;
  logic        ovf;
  logic        cmp;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  int unsigned last_accept = 0;
  int unsigned prev_accept = 0;
  exp_t        scoreboard[$];
  exp_t        last_e;
  logic [5:0]  sel_tab [8] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000,
                               6'b010000, 6'b100000, 6'b000011, 6'b000000};

  serial_adder_cmp #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
`ifdef SERIAL_ADDER_FLUSH_EN
    .flush_i     (flush),
`endif
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .sub_i       (sub),
    .sel_i       (sel),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .cout_o      (cout),
    .zero_o      (zero),
    .neg_o       (neg),
    .ovf_o       (ovf),
    .cmp_o       (cmp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, completion required", $time);
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic msub, input logic [5:0] msel);
    exp_t        e;
    logic [32:0] r;
    longint      d;
    if (msub) begin
      e.sum  = ma - mb;
      e.cout = (ma >= mb);
      d      = longint'($signed(ma)) - longint'($signed(mb));
    end else begin
      r      = {1'b0, ma} + {1'b0, mb};
      e.sum  = r[31:0];
      e.cout = r[32];
      d      = longint'($signed(ma)) + longint'($signed(mb));
    end
    e.zero = (e.sum == 32'd0);
    e.neg  = e.sum[31];
    e.ovf  = (d > 64'sd2147483647) || (d < -64'sd2147483648);
    case (msel)
      SEL_EQ:  e.cmp = e.zero;
      SEL_NE:  e.cmp = !e.zero;
      SEL_LTU: e.cmp = msub ? (ma < mb) : 1'b0;
      SEL_GEU: e.cmp = msub ? (ma >= mb) : 1'b1;
      SEL_LT:  e.cmp = msub ? ($signed(ma) < $signed(mb)) : 1'b0;
      SEL_GE:  e.cmp = msub ? ($signed(ma) >= $signed(mb)) : 1'b1;
      default: e.cmp = 1'b0;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_result(input string tag);
    chk({tag, "_sum"},  sum,  last_e.sum);
    chk({tag, "_cout"}, cout, 32'(last_e.cout));
    chk({tag, "_zero"}, zero, 32'(last_e.zero));
    chk({tag, "_neg"},  neg,  32'(last_e.neg));
    chk({tag, "_ovf"},  ovf,  32'(last_e.ovf));
    chk({tag, "_cmp"},  cmp,  32'(last_e.cmp));
  endtask

  // Accept one operation, optionally pulsing in_valid with junk during CALC, then check at out_valid.
  task automatic do_op(input logic [31:0] oa, input logic [31:0] ob, input logic osub,
                       input logic [5:0] osel, input bit noise);
    int lat;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = oa; b = ob; sub = osub; sel = osel; in_valid = 1'b1;
    scoreboard.push_back(model(oa, ob, osub, osel));
    step();
    prev_accept = last_accept;
    last_accept = cyc;
    in_valid = noise;
    if (noise) begin
      a = $urandom; b = $urandom; sub = ~osub; sel = ~osel;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(lat), 32'(NCHUNK));
    if (scoreboard.size() > 0) last_e = scoreboard.pop_front();
    chk_result("result");
  endtask

  initial begin
    bit seen;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0; sel = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_flags", {27'd0, cout, zero, neg, ovf, cmp}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, SEL_EQ, 1'b0);
    chk("carry_wrap_sum", sum, 32'd0);
    chk("carry_wrap_cout", 32'(cout), 32'd1);
    chk("carry_wrap_zero", 32'(zero), 32'd1);
    chk("carry_wrap_ovf", 32'(ovf), 32'd0);
    step();

    do_op(32'd5, 32'd7, 1'b1, SEL_LT, 1'b0);
    chk("sub_lt_sum", sum, 32'hFFFF_FFFE);
    chk("sub_lt_cmp", 32'(cmp), 32'd1);
    step();
    do_op(32'd5, 32'd7, 1'b1, SEL_LTU, 1'b0);
    chk("sub_ltu_neg", 32'(neg), 32'd1);
    chk("sub_ltu_cmp", 32'(cmp), 32'd1);
    step();

    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, SEL_GE, 1'b0);
    chk("min_ge_sum", sum, 32'h7FFF_FFFF);
    chk("min_ge_ovf", 32'(ovf), 32'd1);
    chk("min_ge_cmp", 32'(cmp), 32'd0);
    step();
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, SEL_GEU, 1'b0);
    chk("min_geu_cmp", 32'(cmp), 32'd1);
    step();

    do_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, SEL_EQ, 1'b1);
    step();
    do_op(32'h0000_0123, 32'h0000_0456, 1'b0, SEL_NE, 1'b0);
    chk("issue_interval", last_accept - prev_accept, 32'(NCHUNK + 2));
    step();

    for (int i = 0; i < 8; i++) begin
      do_op($urandom, $urandom, 1'($urandom_range(0, 1)), sel_tab[i], bit'(i % 2));
      step();
    end

    // Back-pressure: DONE held while in_valid pulses.
    out_ready = 1'b0;
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, SEL_NE, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; sub = 1'b1;
      step();
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_sum", sum, last_e.sum);
      chk("hold_cmp", 32'(cmp), 32'(last_e.cmp));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("idle_sum_held", sum, last_e.sum);

    // Reset during the second CALC cycle.
    a = 32'h1111_1111; b = 32'h2222_2222; sub = 1'b0; sel = SEL_EQ; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_sum", sum, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    do_op(32'd3, 32'd4, 1'b0, SEL_EQ, 1'b0);
    chk("after_rst_sum", sum, 32'd7);
    step();

`ifdef SERIAL_ADDER_FLUSH_EN
    a = 32'hAAAA_0000; b = 32'h0000_5555; sub = 1'b0; sel = SEL_NE; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_sum_kept", sum, last_e.sum);
    seen = 1'b0;
    repeat (NCHUNK + 2) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_valid", 32'(seen), 32'd0);
    do_op(32'd9, 32'd1, 1'b1, SEL_GEU, 1'b0);
    step();
`else
    seen = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
